// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: ring sizing helper, default pointer widths and
// the beat type used by FIFO-side adapters.
package fifo_pkg;

    function automatic int drain_depth(input int lat);
        return lat + 2;
    endfunction

    localparam int DEF_WIDTH = 16;
    localparam int DEF_LAT   = 1;
    localparam int DEF_DEPTH = drain_depth(DEF_LAT);
    localparam int DEF_PTR_W = $clog2(DEF_DEPTH);
    localparam int DEF_CNT_W = DEF_PTR_W + 1;

    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] data;
    } fifo_beat_t;

endpackage

// File: rtl/fifo_drain_ring.sv
// DEPTH x WIDTH register ring with push, pop, clear and occupancy count.
// Pointers wrap at DEPTH, which need not be a power of two.
module fifo_drain_ring #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 3,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fifo_drain_reader.sv
// Read-side controller for the banked FIFO: issues pops, tracks in-flight reads,
// buffers returns in a ring and streams them out. Define FIFO_DRAIN_BYPASS_EN
// to forward a return straight to the output when the ring is empty.
module fifo_drain_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LAT   = 1,
    parameter int DEPTH = drain_depth(LAT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    output logic             fifo_pop,
    input  logic             fifo_valid,
    input  logic [WIDTH-1:0] fifo_rdata,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             err
);

    localparam int IW = $clog2(LAT + 1) + 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    logic [IW-1:0]    inflight;
    logic [IW-1:0]    drop;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] head;
    logic [SW-1:0]    occ;
    logic             pop_ok, ret_ok, keep, push, ring_pop;

    assign pop_ok = fifo_pop && !fifo_empty;
    // A return with nothing outstanding is an error beat and never counts.
    assign ret_ok = fifo_valid && (inflight != '0);
    assign keep   = ret_ok && (drop == '0) && !flush;
    assign occ    = SW'(count) + SW'(inflight);

    assign fifo_pop = rst_n && !fifo_empty && !flush && (drop == '0) && (occ < SW'(DEPTH));

`ifdef FIFO_DRAIN_BYPASS_EN
    logic byp;
    assign byp     = keep && (count == '0);
    assign m_valid = !flush && ((count != '0) || byp);
    assign m_data  = (count != '0) ? head : fifo_rdata;
    assign push    = keep && !(byp && m_ready);
`else
    assign m_valid = !flush && (count != '0);
    assign m_data  = head;
    assign push    = keep;
`endif
    assign ring_pop = m_valid && m_ready && (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            drop     <= '0;
            err      <= 1'b0;
        end else begin
            inflight <= inflight + IW'(pop_ok) - IW'(ret_ok);
            // Everything still outstanding after this cycle's return gets discarded.
            if (flush)
                drop <= inflight - IW'(ret_ok);
            else if (ret_ok && (drop != '0))
                drop <= drop - IW'(1);
            if (fifo_valid && (inflight == '0))
                err <= 1'b1;
        end
    end

    fifo_drain_ring #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ring (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(fifo_rdata),
        .pop      (ring_pop),
        .clear    (flush),
        .head     (head),
        .count    (count)
    );

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Bench for fifo_drain_reader: a latency-LAT FIFO model feeds the DUT and a
// scoreboard expects every accepted pop back in order unless flushed.
module tb_fifo_drain_reader;

    localparam int WIDTH = 16;
    localparam int LAT   = 2;
    localparam int DEPTH = LAT + 2;
`ifdef FIFO_DRAIN_BYPASS_EN
    localparam int EXP_LAT = LAT;
`else
    localparam int EXP_LAT = LAT + 1;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic fifo_empty = 1'b1, fifo_pop, fifo_valid = 1'b0, flush = 1'b0;
    logic m_valid, m_ready = 1'b0, err;
    logic [WIDTH-1:0] fifo_rdata = '0, m_data;

    int checks = 0, errors = 0, cyc = 0;
    logic [WIDTH-1:0] src_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic             pend_v [LAT];
    logic [WIDTH-1:0] pend_d [LAT];

    int rdy_mode = 0;   // 0 low, 1 high, 2 random
    int gap_pct  = 0;
    logic stray  = 1'b0;
    int pop_cnt, pop_first, pop_last;
    int beat_cnt, beat_first, beat_last;
    int flush_at_pop = -1, flush_cyc, post_flush_pop;
    logic             pf_seen;
    logic [WIDTH-1:0] pf_data;

    fifo_drain_reader #(.WIDTH(WIDTH), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_empty(fifo_empty),
        .fifo_pop  (fifo_pop),
        .fifo_valid(fifo_valid),
        .fifo_rdata(fifo_rdata),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #3;
    endtask

    task automatic reset_stats();
        pop_cnt = 0; pop_first = -1; pop_last = -1;
        beat_cnt = 0; beat_first = -1; beat_last = -1;
        flush_cyc = -1; post_flush_pop = -1; pf_seen = 1'b0; pf_data = '0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < bound) begin
            step(1);
            n++;
        end
        step(LAT + 3);
        checks++;
        if (n >= bound) begin
            errors++;
            $display("FAIL %s_timeout: waited %0d cycles, required under %0d", name, n, bound);
        end
    endtask

    // FIFO model: accepted pops return their word LAT cycles later.
    initial begin
        logic [WIDTH-1:0] w;
        for (int i = 0; i < LAT; i++) begin pend_v[i] = 1'b0; pend_d[i] = '0; end
        forever begin
            @(negedge clk);
            cyc++;
            if (stray) begin
                fifo_valid = 1'b1; fifo_rdata = 16'hdead; stray = 1'b0;
            end else begin
                fifo_valid = pend_v[0]; fifo_rdata = pend_v[0] ? pend_d[0] : '0;
            end
            for (int i = 0; i < LAT - 1; i++) begin
                pend_v[i] = pend_v[i+1]; pend_d[i] = pend_d[i+1];
            end
            pend_v[LAT-1] = 1'b0;
            fifo_empty = (src_q.size() == 0) || ($urandom_range(99) < gap_pct);
            case (rdy_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(1));
            endcase
            flush = (flush_at_pop >= 0) && (pop_cnt == flush_at_pop);
            if (flush) begin
                flush_at_pop = -1; flush_cyc = cyc; exp_q.delete();
            end
            #1;
            if (rst_n && fifo_pop && !fifo_empty) begin
                w = src_q.pop_front();
                pend_v[LAT-1] = 1'b1; pend_d[LAT-1] = w;
                exp_q.push_back(w);
                pop_cnt++;
                if (pop_first < 0) pop_first = cyc;
                pop_last = cyc;
                if (flush_cyc >= 0 && post_flush_pop < 0) post_flush_pop = cyc;
            end
        end
    end

    // Monitor: pops expectations on every transfer, checks stall stability.
    initial begin
        logic pv = 1'b0, pr = 1'b0;
        logic [WIDTH-1:0] pd = '0, e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin pv = 1'b0; continue; end
            if (flush)
                chk("m_valid_in_flush", m_valid, 0);
            else if (pv && !pr) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, pd);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e);
                end
                beat_cnt++;
                if (beat_first < 0) beat_first = cyc;
                beat_last = cyc;
                if (flush_cyc >= 0 && !pf_seen) begin pf_seen = 1'b1; pf_data = m_data; end
            end
            pv = m_valid; pr = m_ready; pd = m_data;
        end
    end

    initial begin
        int n;
        reset_stats();
        step(3);
        chk("rst_fifo_pop", fifo_pop, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        step(2);

        // Back-to-back stream of 8 words
        reset_stats(); rdy_mode = 1;
        for (int i = 1; i <= 8; i++) src_q.push_back(WIDTH'(i));
        wait_idle("stream8", 200);
        chk("pop_span", pop_last - pop_first, 7);
        chk("beat_cnt8", beat_cnt, 8);
        chk("first_latency", beat_first - pop_first, EXP_LAT);
        chk("beat_span", beat_last - beat_first, 7);

        // Backpressure: pops stop at DEPTH, drain in order, then resume
        reset_stats(); rdy_mode = 0;
        for (int i = 0; i < 20; i++) src_q.push_back(WIDTH'(16'h100 + i));
        step(20);
        chk("bp_pops", pop_cnt, DEPTH);
        chk("bp_fifo_pop", fifo_pop, 0);
        chk("bp_no_beats", beat_cnt, 0);
        rdy_mode = 1;
        wait_idle("bp_drain", 400);
        chk("bp_total_pops", pop_cnt, 20);
        chk("bp_total_beats", beat_cnt, 20);

        // Empty FIFO: nothing produced
        reset_stats();
        step(10);
        chk("empty_beats", beat_cnt, 0);
        chk("empty_pops", pop_cnt, 0);

        // Flush with two reads in flight and one word buffered
        reset_stats(); rdy_mode = 0;
        for (int i = 0; i < 10; i++) src_q.push_back(WIDTH'(16'h200 + i));
        flush_at_pop = 3;
        n = 0;
        while (flush_cyc < 0 && n < 50) begin step(1); n++; end
        chk("flush_seen", flush_cyc >= 0, 1);
        rdy_mode = 1;
        wait_idle("flush_drain", 400);
        chk("flush_resume_gap", post_flush_pop - flush_cyc, LAT);
        chk("flush_first_data", pf_data, 16'h203);
        chk("flush_beats", beat_cnt, 7);
        chk("flush_err", err, 0);

        // Stray return sets sticky err, produces no beat
        reset_stats(); stray = 1'b1;
        step(3);
        chk("err_set", err, 1);
        chk("err_no_beat", beat_cnt, 0);
        step(5);
        chk("err_sticky", err, 1);
        rst_n = 1'b0;
        step(1);
        chk("err_reset", err, 0);
        rst_n = 1'b1;
        step(2);

        // Random ready and FIFO gaps over 1000 words
        reset_stats(); rdy_mode = 2; gap_pct = 20;
        for (int i = 0; i < 1000; i++) src_q.push_back(WIDTH'($urandom));
        wait_idle("random", 20000);
        chk("rand_beats", beat_cnt, 1000);
        chk("rand_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
